rot_imm_encoder: RTL and testbench

//  Encoder counterpart of the execute-stage operand shifter. Takes a 32-bit constant and searches for the

---
 rtl/leg_pkg.sv | 25 ++
 rtl/rot_imm_check.sv | 18 +
 rtl/rot_imm_encoder.sv | 182 ++++++++++++++++++
 tb/tb_rot_imm_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leg_pkg.sv
// Shared types and helpers for the rotated-immediate encoder: FSM states,
// the {rot, imm8} encoding record and a 32-bit rotate-left helper.
package leg_pkg;

    localparam int ROT_STEPS = 16;

    typedef enum logic [1:0] {
        RIE_IDLE   = 2'd0,
        RIE_SEARCH = 2'd1,
        RIE_DONE   = 2'd2
    } rie_state_t;

    typedef struct packed {
        logic [3:0] rot;
        logic [7:0] imm8;
    } rot_imm_t;

    // Upper half of the doubled word shifted left is exactly value ROL amount.
    function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
        logic [63:0] wide_s;
        wide_s = {value, value} << amount;
        return wide_s[63:32];
    endfunction

endpackage

// File: rtl/rot_imm_check.sv
// Tests one rotation of a candidate value: it fits if rotating left by 2*rot
// leaves nothing above the low byte, which then becomes imm8.
module rot_imm_check
    import leg_pkg::*;
(
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [31:0] rolled_s;

    assign rolled_s = rol32(value, {rot, 1'b0});
    assign hit      = (rolled_s[31:8] == 24'h000000);
    assign imm8     = rolled_s[7:0];

endmodule

// File: rtl/rot_imm_encoder.sv
// Multi-cycle search for the rotated-immediate (or MVN) encoding of a 32-bit
// constant, CHECKS_PER_CYCLE rotations per cycle, valid/ready on both sides.
module rot_imm_encoder
    import leg_pkg::*;
#(
    parameter int CHECKS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_found,
    output logic        out_mvn,
    output logic [11:0] out_imm12,
    output logic        out_c_keep,
    output logic        out_c
);

    localparam int         N        = CHECKS_PER_CYCLE;
    localparam logic [3:0] LAST_CNT = 4'(ROT_STEPS - N);
    localparam logic [3:0] CNT_STEP = 4'(N);

    rie_state_t state_r, next_state_s;
    logic [31:0] value_r;
    logic [3:0]  cnt_r;
    logic        in_ready_r;
    logic        mvn_hit_r;
    rot_imm_t    mvn_enc_r;
    logic        out_valid_r, out_found_r, out_mvn_r, out_c_keep_r, out_c_r;
    rot_imm_t    out_enc_r;

    logic [N-1:0] dir_hit_s, mvn_hit_s;
    logic [7:0]   dir_imm_s [N];
    logic [7:0]   mvn_imm_s [N];
    logic [3:0]   grp_rot_s [N];

    for (genvar g = 0; g < N; g++) begin : g_check
        assign grp_rot_s[g] = cnt_r + 4'(g);
        rot_imm_check u_dir (.value(value_r),  .rot(grp_rot_s[g]), .hit(dir_hit_s[g]), .imm8(dir_imm_s[g]));
        rot_imm_check u_mvn (.value(~value_r), .rot(grp_rot_s[g]), .hit(mvn_hit_s[g]), .imm8(mvn_imm_s[g]));
    end

    logic     dir_any_s, mvn_any_s, last_grp_s, mvn_use_hit_s;
    rot_imm_t dir_enc_s, mvn_enc_s, mvn_use_enc_s;

    assign dir_any_s     = |dir_hit_s;
    assign mvn_any_s     = |mvn_hit_s;
    assign last_grp_s    = (cnt_r == LAST_CNT);
    assign mvn_use_hit_s = mvn_hit_r | mvn_any_s;
    assign mvn_use_enc_s = mvn_hit_r ? mvn_enc_r : mvn_enc_s;

    // Pick the smallest rotation in this group for each candidate (descending scan).
    always_comb begin
        dir_enc_s = '0;
        mvn_enc_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            dir_enc_s = dir_hit_s[i] ? {grp_rot_s[i], dir_imm_s[i]} : dir_enc_s;
            mvn_enc_s = mvn_hit_s[i] ? {grp_rot_s[i], mvn_imm_s[i]} : mvn_enc_s;
        end
    end

    logic     res_found_s, res_mvn_s, res_c_keep_s, res_c_s;
    rot_imm_t res_enc_s;

    // Result to latch when the search ends; carry follows bit 31 of the encoded value.
    always_comb begin
        res_found_s  = 1'b0;
        res_mvn_s    = 1'b0;
        res_enc_s    = '0;
        res_c_keep_s = 1'b0;
        res_c_s      = 1'b0;
        if (dir_any_s) begin
            res_found_s  = 1'b1;
            res_enc_s    = dir_enc_s;
            res_c_keep_s = (dir_enc_s.rot == 4'd0);
            res_c_s      = (dir_enc_s.rot != 4'd0) & value_r[31];
        end else if (mvn_use_hit_s) begin
            res_found_s  = 1'b1;
            res_mvn_s    = 1'b1;
            res_enc_s    = mvn_use_enc_s;
            res_c_keep_s = (mvn_use_enc_s.rot == 4'd0);
            res_c_s      = (mvn_use_enc_s.rot != 4'd0) & ~value_r[31];
        end else begin
            res_found_s  = 1'b0;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RIE_IDLE:   next_state_s = in_valid ? RIE_SEARCH : RIE_IDLE;
            RIE_SEARCH: next_state_s = (dir_any_s || last_grp_s) ? RIE_DONE : RIE_SEARCH;
            RIE_DONE:   next_state_s = out_ready ? RIE_IDLE : RIE_DONE;
            default:    next_state_s = RIE_IDLE;
        endcase
        if (flush) begin
            next_state_s = RIE_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register and registered in_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= RIE_IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == RIE_IDLE);
        end
    end

    // Datapath: value capture, rotation counter, first MVN hit and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || flush) begin
            value_r      <= 32'h0;
            cnt_r        <= 4'd0;
            mvn_hit_r    <= 1'b0;
            mvn_enc_r    <= '0;
            out_valid_r  <= 1'b0;
            out_found_r  <= 1'b0;
            out_mvn_r    <= 1'b0;
            out_enc_r    <= '0;
            out_c_keep_r <= 1'b0;
            out_c_r      <= 1'b0;
        end else begin
            case (state_r)
                RIE_IDLE: begin
                    if (in_valid) begin
                        value_r   <= in_value;
                        cnt_r     <= 4'd0;
                        mvn_hit_r <= 1'b0;
                        mvn_enc_r <= '0;
                    end
                end
                RIE_SEARCH: begin
                    cnt_r <= cnt_r + CNT_STEP;
                    if (!mvn_hit_r && mvn_any_s) begin
                        mvn_hit_r <= 1'b1;
                        mvn_enc_r <= mvn_enc_s;
                    end
                    if (dir_any_s || last_grp_s) begin
                        out_valid_r  <= 1'b1;
                        out_found_r  <= res_found_s;
                        out_mvn_r    <= res_mvn_s;
                        out_enc_r    <= res_enc_s;
                        out_c_keep_r <= res_c_keep_s;
                        out_c_r      <= res_c_s;
                    end
                end
                RIE_DONE: begin
                    if (out_ready) begin
                        out_valid_r  <= 1'b0;
                        out_found_r  <= 1'b0;
                        out_mvn_r    <= 1'b0;
                        out_enc_r    <= '0;
                        out_c_keep_r <= 1'b0;
                        out_c_r      <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_found  = out_found_r;
    assign out_mvn    = out_mvn_r;
    assign out_imm12  = out_enc_r;
    assign out_c_keep = out_c_keep_r;
    assign out_c      = out_c_r;

endmodule

// File: tb/tb_rot_imm_encoder.sv
// Bench for rot_imm_encoder: one instance with one check per cycle and one
// with four, driven in lockstep and compared to constants and a rotation model.
module tb_rot_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_value = 32'h0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, out_found1, out_mvn1, out_c_keep1, out_c1;
    logic [11:0] out_imm12_1;
    logic        in_ready4, out_valid4, out_found4, out_mvn4, out_c_keep4, out_c4;
    logic [11:0] out_imm12_4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cur_value = 32'h0;

    always #5 clk = ~clk;

    rot_imm_encoder #(.CHECKS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_value(in_value), .out_valid(out_valid1), .out_ready(out_ready), .out_found(out_found1),
        .out_mvn(out_mvn1), .out_imm12(out_imm12_1), .out_c_keep(out_c_keep1), .out_c(out_c1)
    );

    rot_imm_encoder #(.CHECKS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_value(in_value), .out_valid(out_valid4), .out_ready(out_ready), .out_found(out_found4),
        .out_mvn(out_mvn4), .out_imm12(out_imm12_4), .out_c_keep(out_c_keep4), .out_c(out_c4)
    );

    typedef struct {
        logic [31:0] value;
        logic        found;
        logic        mvn;
        logic [11:0] imm12;
        logic        c_keep;
        logic        c;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s value=%h actual=%h expected=%h", nm, cur_value, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < s; i++) t = {t[30:0], t[31]};
        return t;
    endfunction

    // Reference: scan all 16 rotations of the value, then of its complement.
    task automatic model(input logic [31:0] v, output vec_t e);
        int          dr, mr, r;
        logic [31:0] t, tv;
        dr = -1;
        mr = -1;
        for (int k = 0; k < 16; k++) begin
            t = rol(v, 2 * k);
            if (dr < 0 && t[31:8] == 24'h0) dr = k;
            t = rol(~v, 2 * k);
            if (mr < 0 && t[31:8] == 24'h0) mr = k;
        end
        e.value = v;
        e.found = 1'b0; e.mvn = 1'b0; e.imm12 = 12'h0; e.c_keep = 1'b0; e.c = 1'b0;
        e.lat1 = 16; e.lat4 = 4;
        if (dr >= 0 || mr >= 0) begin
            r  = (dr >= 0) ? dr : mr;
            tv = (dr >= 0) ? v : ~v;
            t  = rol(tv, 2 * r);
            e.found  = 1'b1;
            e.mvn    = (dr < 0);
            e.imm12  = {4'(r), t[7:0]};
            e.c_keep = (r == 0);
            e.c      = (r != 0) && tv[31];
            if (dr >= 0) begin
                e.lat1 = dr + 1;
                e.lat4 = dr / 4 + 1;
            end
        end
    endtask

    task automatic accept(input logic [31:0] v);
        cur_value = v;
        in_value  = v;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t e);
        int l1, l4, cyc;
        accept(e.value);
        chk("busy_ready1", in_ready1, 1'b0);
        chk("busy_ready4", in_ready4, 1'b0);
        l1 = 0; l4 = 0; cyc = 0;
        while ((l1 == 0 || l4 == 0) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (l1 == 0 && out_valid1) l1 = cyc;
            if (l4 == 0 && out_valid4) l4 = cyc;
        end
        chk("latency1", l1, e.lat1);
        chk("latency4", l4, e.lat4);
        chk("found1", out_found1, e.found);
        chk("found4", out_found4, e.found);
        chk("mvn1", out_mvn1, e.mvn);
        chk("mvn4", out_mvn4, e.mvn);
        chk("imm12_1", out_imm12_1, e.imm12);
        chk("imm12_4", out_imm12_4, e.imm12);
        chk("c_keep1", out_c_keep1, e.c_keep);
        chk("c_keep4", out_c_keep4, e.c_keep);
        chk("c1", out_c1, e.c);
        chk("c4", out_c4, e.c);
        release_out();
        chk("idle_ready1", in_ready1, 1'b1);
        chk("idle_ready4", in_ready4, 1'b1);
        chk("idle_valid1", out_valid1, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog value=%h actual=timeout expected=finish", cur_value);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        logic [31:0] v;
        int   seen;

        vecs[0] = '{32'h000000FF, 1'b1, 1'b0, 12'h0FF, 1'b1, 1'b0,  1, 1};
        vecs[1] = '{32'hFF000000, 1'b1, 1'b0, 12'h4FF, 1'b0, 1'b1,  5, 2};
        vecs[2] = '{32'hF000000F, 1'b1, 1'b0, 12'h2FF, 1'b0, 1'b1,  3, 1};
        vecs[3] = '{32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 1'b1, 1'b0, 16, 4};
        vecs[4] = '{32'h00000102, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 16, 4};
        vecs[5] = '{32'h00000000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0,  1, 1};
        vecs[6] = '{32'h000003FC, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b0, 16, 4};
        vecs[7] = '{32'h80000001, 1'b1, 1'b0, 12'h106, 1'b0, 1'b1,  2, 1};
        vecs[8] = '{32'hFFFFFFFF, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 16, 4};
        vecs[9] = '{32'h7FFFFFFF, 1'b1, 1'b1, 12'h102, 1'b0, 1'b1, 16, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready1", in_ready1, 1'b1);
        chk("rst_valid1", out_valid1, 1'b0);
        chk("rst_imm12_4", out_imm12_4, 12'h000);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Result held while the consumer stalls.
        accept(32'h000000FF);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid1", out_valid1, 1'b1);
            chk("hold_imm12_1", out_imm12_1, 12'h0FF);
            chk("hold_found1", out_found1, 1'b1);
            chk("hold_ready1", in_ready1, 1'b0);
        end
        release_out();

        // Flush in the third search cycle drops the result.
        accept(32'h00000102);
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready1", in_ready1, 1'b1);
        chk("flush_ready4", in_ready4, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4) seen = 1;
        end
        chk("flush_no_valid", seen, 0);

        // Asynchronous reset mid-search, then while a result is held.
        accept(32'h00000102);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #2;
        chk("arst_ready1", in_ready1, 1'b1);
        chk("arst_ready4", in_ready4, 1'b1);
        chk("arst_valid1", out_valid1, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4) seen = 1;
        end
        chk("arst_no_valid", seen, 0);
        run_vec(vecs[5]);

        accept(32'hFF000000);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        chk("arst_done_valid4", out_valid4, 1'b0);
        chk("arst_done_imm12_4", out_imm12_4, 12'h000);
        chk("arst_done_found4", out_found4, 1'b0);
        chk("arst_done_c4", out_c4, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Random values: rotated bytes, their complements, arbitrary words.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: v = rol(32'($urandom_range(0, 255)), (32 - 2 * $urandom_range(0, 15)) % 32);
                1: v = ~rol(32'($urandom_range(0, 255)), (32 - 2 * $urandom_range(0, 15)) % 32);
                2: v = 32'($urandom_range(0, 1023)) << $urandom_range(0, 22);
                default: v = $urandom;
            endcase
            model(v, e);
            run_vec(e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
